// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: round-robin N-to-1 arbiter for a shared dcache request
// port. It handles the two-phase load protocol (index/grant, then tag one
// cycle later) and routes read responses back through an outstanding-ID FIFO.
// Optional feature macro: DCACHE_ARB_PERF_EN enables the stall counter on
// perf_stall_o. When the macro is undefined, perf_stall_o is tied to zero.
module dcache_req_arbiter #(
  parameter int NR_PORTS = 3,
  parameter int IDX_W    = 12,
  parameter int TAG_W    = 44,
  parameter int DATA_W   = 64,
  parameter int OUTST    = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NR_PORTS-1:0]                 req_i,
  input  logic [NR_PORTS-1:0]                 we_i,
  input  logic [NR_PORTS-1:0][IDX_W-1:0]      index_i,
  input  logic [NR_PORTS-1:0][TAG_W-1:0]      tag_i,
  input  logic [NR_PORTS-1:0][DATA_W-1:0]     wdata_i,
  input  logic [NR_PORTS-1:0][DATA_W/8-1:0]   be_i,
  input  logic [NR_PORTS-1:0][1:0]            size_i,
  input  logic [NR_PORTS-1:0]                 tag_valid_i,
  input  logic [NR_PORTS-1:0]                 kill_i,
  output logic [NR_PORTS-1:0]                 gnt_o,
  output logic [NR_PORTS-1:0]                 rvalid_o,
  output logic [DATA_W-1:0]                   rdata_o,
  output logic                                cache_req_o,
  output logic                                cache_we_o,
  output logic [IDX_W-1:0]                    cache_index_o,
  output logic [TAG_W-1:0]                    cache_tag_o,
  output logic [DATA_W-1:0]                   cache_wdata_o,
  output logic [DATA_W/8-1:0]                 cache_be_o,
  output logic [1:0]                          cache_size_o,
  output logic                                cache_tag_valid_o,
  output logic                                cache_kill_o,
  input  logic                                cache_gnt_i,
  input  logic                                cache_rvalid_i,
  input  logic [DATA_W-1:0]                   cache_rdata_i,
  output logic                                err_o,
  output logic [31:0]                         perf_stall_o
);

  localparam int SEL_W = $clog2(NR_PORTS);
  localparam int PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOCK, TAG} state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     rr_q, rr_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     tag_id_q, tag_id_d;
  logic                 err_q, err_d;
  logic [SEL_W-1:0]     fifo_mem_q [OUTST];
  logic [SEL_W-1:0]     fifo_mem_d [OUTST];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 fifo_full, fifo_empty;
  logic [NR_PORTS-1:0]  elig;
  logic [SEL_W-1:0]     pick;
  logic                 pick_vld;
  logic [SEL_W-1:0]     cur;
  logic                 drive;
  logic                 push, pop;

  assign fifo_full  = (cnt_q == CNT_W'(OUTST));
  assign fifo_empty = (cnt_q == '0);
  // A read needs a free ID slot. A write never returns data, so it can proceed when the FIFO is full.
  assign elig       = req_i & (we_i | {NR_PORTS{~fifo_full}});
  assign err_o      = err_q;

  // Round-robin pick: first eligible port at or after rr_q, wrapping
  always_comb begin
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 0; k < NR_PORTS; k++) begin
      idx = (int'(rr_q) + k) % NR_PORTS;
      if (!pick_vld && elig[idx]) begin
        pick_vld = 1'b1;
        pick     = SEL_W'(idx);
      end
    end
  end

  // FSM next state, request mux, grant fan-out, and response routing
  always_comb begin
    state_d           = state_q;
    rr_d              = rr_q;
    sel_d             = sel_q;
    tag_id_d          = tag_id_q;
    err_d             = err_q;
    push              = 1'b0;
    pop               = 1'b0;
    cur               = '0;
    drive             = 1'b0;
    gnt_o             = '0;
    rvalid_o          = '0;
    rdata_o           = '0;
    cache_req_o       = 1'b0;
    cache_we_o        = 1'b0;
    cache_index_o     = '0;
    cache_tag_o       = '0;
    cache_wdata_o     = '0;
    cache_be_o        = '0;
    cache_size_o      = '0;
    cache_tag_valid_o = 1'b0;
    cache_kill_o      = 1'b0;

    // Outputs stay quiet while reset is held, even when requests are asserted.
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            cur   = pick;
            drive = 1'b1;
            if (!cache_gnt_i) begin
              sel_d   = pick;
              state_d = LOCK;
            end
          end
        end
        LOCK: begin
          cur = sel_q;
          if (!req_i[sel_q]) begin
            // The requester withdrew before the cache granted it.
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (elig[sel_q]) begin
            drive = 1'b1;
          end
        end
        TAG: begin
          cache_tag_o       = tag_i[tag_id_q];
          cache_tag_valid_o = tag_valid_i[tag_id_q];
          cache_kill_o      = kill_i[tag_id_q];
          state_d           = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (drive) begin
        cache_req_o       = 1'b1;
        cache_we_o        = we_i[cur];
        cache_index_o     = index_i[cur];
        cache_tag_o       = tag_i[cur];
        cache_wdata_o     = wdata_i[cur];
        cache_be_o        = be_i[cur];
        cache_size_o      = size_i[cur];
        cache_tag_valid_o = tag_valid_i[cur];
        cache_kill_o      = kill_i[cur];
        if (cache_gnt_i) begin
          gnt_o[cur] = 1'b1;
          rr_d       = SEL_W'((int'(cur) + 1) % NR_PORTS);
          if (!we_i[cur]) begin
            push     = 1'b1;
            tag_id_d = cur;
            state_d  = TAG;
          end else begin
            state_d  = IDLE;
          end
        end
      end

      rdata_o = cache_rdata_i;
      if (cache_rvalid_i) begin
        if (fifo_empty) begin
          err_d = 1'b1;
        end else begin
          pop                          = 1'b1;
          rvalid_o[fifo_mem_q[rd_ptr_q]] = 1'b1;
        end
      end
    end
  end

  // Outstanding-ID FIFO bookkeeping
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = cur;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      sel_q    <= '0;
      tag_id_q <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      tag_id_q <= tag_id_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; the pointers and count define validity, so no reset is needed here
  always_ff @(posedge clk_i) begin
    fifo_mem_q <= fifo_mem_d;
  end

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where someone requests and nobody is granted
  always_comb begin
    stall_d = stall_q;
    if ((|req_i) && !(|gnt_o) && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign perf_stall_o = stall_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule
